// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: FSM state encodings, control-output bundle and sizing helper
package pipeline_ctrl_pkg;
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    REDIRECT = 2'd2,
    MEM_WAIT = 2'd3
  } state_t;
  typedef struct packed {
    logic pc_we;
    logic if_id_we;
    logic if_id_flush;
    logic id_ex_we;
    logic id_ex_flush;
    logic ex_mem_we;
    logic mem_wb_bubble;
  } ctrl_t;
  localparam ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam ctrl_t CTRL_RST    = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam ctrl_t CTRL_BRANCH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam ctrl_t CTRL_REDIR  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam ctrl_t CTRL_LU     = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  function automatic int rem_width(int a, int b);
    return $clog2((a > b ? a : b) + 1);
  endfunction
endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard inputs from ID/EX/MEM and stall/flush controls back to the pipeline
interface pipeline_ctrl_if #(parameter int CNT_W = 16);
  logic [4:0]       id_rs1_addr;
  logic [4:0]       id_rs2_addr;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic [4:0]       ex_rd_addr;
  logic             ex_mem_read_en;
  logic             ex_reg_write_en;
  logic             ex_branch_taken;
  logic             mem_req_valid;
  logic             dmem_ready;
  logic             pc_we;
  logic             if_id_we;
  logic             if_id_flush;
  logic             id_ex_we;
  logic             id_ex_flush;
  logic             ex_mem_we;
  logic             mem_wb_bubble;
  logic [CNT_W-1:0] stall_cnt;
  logic [1:0]       state_o;
  modport master (
    output id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2, ex_rd_addr,
           ex_mem_read_en, ex_reg_write_en, ex_branch_taken, mem_req_valid, dmem_ready,
    input  pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we,
           mem_wb_bubble, stall_cnt, state_o
  );
  modport slave (
    input  id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2, ex_rd_addr,
           ex_mem_read_en, ex_reg_write_en, ex_branch_taken, mem_req_valid, dmem_ready,
    output pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we,
           mem_wb_bubble, stall_cnt, state_o
  );
endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// hazard_detect: load-use hazard between the load in EX and the source registers read in ID
module hazard_detect (
  input  logic [4:0] i_rs1_addr,
  input  logic [4:0] i_rs2_addr,
  input  logic       i_uses_rs1,
  input  logic       i_uses_rs2,
  input  logic [4:0] i_rd_addr,
  input  logic       i_mem_read_en,
  input  logic       i_reg_write_en,
  output logic       o_lu_haz
);
  logic w_rs1_hit, w_rs2_hit;
  assign w_rs1_hit = i_uses_rs1 & (i_rs1_addr == i_rd_addr);
  assign w_rs2_hit = i_uses_rs2 & (i_rs2_addr == i_rd_addr);
  assign o_lu_haz  = i_mem_read_en & i_reg_write_en & (i_rd_addr != 5'd0) & (w_rs1_hit | w_rs2_hit);
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for load-use, branch redirect and data-memory wait
module pipeline_ctrl import pipeline_ctrl_pkg::*; #(
  parameter int LOAD_LAT        = 1,
  parameter int REDIRECT_CYCLES = 1,
  parameter int CNT_W           = 16
) (
  input logic          clk,
  input logic          rst,
  pipeline_ctrl_if.slave ctrl
);
  localparam int REM_W = rem_width(LOAD_LAT, REDIRECT_CYCLES);
  localparam logic [REM_W-1:0] REM_ONE = REM_W'(1);
  state_t           r_state, r_ret_state, w_state_nx, w_ret_nx, w_eff;
  logic [REM_W-1:0] r_rem, w_rem_nx;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_lu_haz, w_mwait;
  ctrl_t            w_ctrl;
  hazard_detect u_hazard_detect (
    .i_rs1_addr    (ctrl.id_rs1_addr),
    .i_rs2_addr    (ctrl.id_rs2_addr),
    .i_uses_rs1    (ctrl.id_uses_rs1),
    .i_uses_rs2    (ctrl.id_uses_rs2),
    .i_rd_addr     (ctrl.ex_rd_addr),
    .i_mem_read_en (ctrl.ex_mem_read_en),
    .i_reg_write_en(ctrl.ex_reg_write_en),
    .o_lu_haz      (w_lu_haz)
  );
  assign w_mwait = ctrl.mem_req_valid & ~ctrl.dmem_ready;
  // the cycle memory becomes ready behaves exactly like the state that was interrupted
  assign w_eff = (r_state == MEM_WAIT) ? r_ret_state : r_state;
  always_comb begin
    w_ctrl     = CTRL_RUN;
    w_state_nx = w_eff;
    w_ret_nx   = r_ret_state;
    w_rem_nx   = r_rem;
    if (rst) begin
      w_ctrl = CTRL_RST;
    end else if (w_mwait) begin
      w_ctrl     = CTRL_FREEZE;
      w_state_nx = MEM_WAIT;
      w_ret_nx   = (r_state == MEM_WAIT) ? r_ret_state : r_state;
    end else if (ctrl.ex_branch_taken) begin
      w_ctrl     = CTRL_BRANCH;
      w_state_nx = (REDIRECT_CYCLES > 1) ? REDIRECT : RUN;
      w_rem_nx   = REM_W'(REDIRECT_CYCLES - 1);
    end else if (w_eff == REDIRECT) begin
      w_ctrl     = CTRL_REDIR;
      w_rem_nx   = r_rem - REM_ONE;
      w_state_nx = (r_rem == REM_ONE) ? RUN : REDIRECT;
    end else if (w_eff == LU_STALL || w_lu_haz) begin
      w_ctrl     = CTRL_LU;
      w_rem_nx   = (w_eff == LU_STALL) ? r_rem - REM_ONE : REM_W'(LOAD_LAT - 1);
      w_state_nx = ((w_eff == LU_STALL) ? (r_rem == REM_ONE) : (LOAD_LAT == 1)) ? RUN : LU_STALL;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= RUN;
      r_ret_state <= RUN;
      r_rem       <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_ret_state <= w_ret_nx;
      r_rem       <= w_rem_nx;
      if (!w_ctrl.pc_we && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end
  assign ctrl.pc_we         = w_ctrl.pc_we;
  assign ctrl.if_id_we      = w_ctrl.if_id_we;
  assign ctrl.if_id_flush   = w_ctrl.if_id_flush;
  assign ctrl.id_ex_we      = w_ctrl.id_ex_we;
  assign ctrl.id_ex_flush   = w_ctrl.id_ex_flush;
  assign ctrl.ex_mem_we     = w_ctrl.ex_mem_we;
  assign ctrl.mem_wb_bubble = w_ctrl.mem_wb_bubble;
  assign ctrl.stall_cnt     = r_stall_cnt;
  assign ctrl.state_o       = r_state;
endmodule
